// File: rtl/bubble.sv
// bubble: two-entry skid-buffer pipeline slice for a valid/ready stream.
// Registers both the forward path (vld_b, data_b) and the backward path
// (rdy_a), so no input reaches any output combinationally. It sustains one
// word per cycle.
// Optional feature macro: BUBBLE_STATS_EN adds the xfer_cnt and full_o ports.
module bubble #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_a,
    input  logic             vld_a,
    output logic             rdy_a,
    output logic [WIDTH-1:0] data_b,
    output logic             vld_b,
    input  logic             rdy_b
`ifdef BUBBLE_STATS_EN
    ,
    output logic [31:0]      xfer_cnt,
    output logic             full_o
`endif
);

    // EMPTY: no word held, HALF: main only, FULL: main and skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_a_q;
    logic             vld_b_q;

    logic             xfer_a;
    logic             xfer_b;

    // Handshakes are evaluated against the registered ready/valid only
    assign xfer_a = vld_a && rdy_a_q;
    assign xfer_b = vld_b_q && rdy_b;

    assign rdy_a  = rdy_a_q;
    assign vld_b  = vld_b_q;
    assign data_b = main_q;

    // Next-state and next-data selection for the two storage slots
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_a) begin
                    main_d  = data_a;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (xfer_a && xfer_b) begin
                    main_d = data_a;
                end else if (xfer_a) begin
                    skid_d  = data_a;
                    state_d = ST_FULL;
                end else if (xfer_b) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // rdy_a is low here, so only the drain side can move
                if (xfer_b) begin
                    main_d  = skid_q;
                    state_d = ST_HALF;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State and handshake registers; outputs follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rdy_a_q <= 1'b0;
            vld_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_a_q <= (state_d != ST_FULL);
            vld_b_q <= (state_d != ST_EMPTY);
        end
    end

    // Payload registers carry no reset; validity is tracked by state_q
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

`ifdef BUBBLE_STATS_EN
    localparam int unsigned CNT_W = 32;

    logic [CNT_W-1:0] cnt_q;
    logic             full_q;

    assign xfer_cnt = cnt_q;
    assign full_o   = full_q;

    // Downstream transfer counter (wraps) and registered FULL flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (xfer_b) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            full_q <= (state_d == ST_FULL);
        end
    end
`endif

endmodule

// File: tb/tb_bubble.sv
// tb_bubble: directed bench for the bubble skid buffer with a small
// occupancy/queue reference model checked after every clock edge.
module tb_bubble;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_a;
    logic             vld_a;
    logic             rdy_a;
    logic [WIDTH-1:0] data_b;
    logic             vld_b;
    logic             rdy_b;
`ifdef BUBBLE_STATS_EN
    logic [31:0]      xfer_cnt;
    logic             full_o;
`endif

    bubble #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .data_a (data_a),
        .vld_a  (vld_a),
        .rdy_a  (rdy_a),
        .data_b (data_b),
        .vld_b  (vld_b),
        .rdy_b  (rdy_b)
`ifdef BUBBLE_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .full_o   (full_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words held in order, plus expected handshake levels
    logic [31:0] exp_q[$];
    logic        m_rdy = 1'b0;
    logic        m_vld = 1'b0;
    logic [31:0] m_cnt = 32'd0;
    int          b_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge: advance the model, then compare outputs 1 time unit later
    task automatic tick();
        logic ax;
        logic bx;
        ax = vld_a && m_rdy && !rst;
        bx = m_vld && rdy_b && !rst;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_rdy = 1'b0;
            m_vld = 1'b0;
            m_cnt = 32'd0;
        end else begin
            if (bx) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + 32'd1;
                b_total++;
            end
            if (ax) exp_q.push_back(data_a);
            m_rdy = (exp_q.size() < 2);
            m_vld = (exp_q.size() != 0);
        end
        #1;
        check("rdy_a", 32'(rdy_a), 32'(m_rdy));
        check("vld_b", 32'(vld_b), 32'(m_vld));
        if (m_vld) check("data_b", data_b, exp_q[0]);
`ifdef BUBBLE_STATS_EN
        check("xfer_cnt", xfer_cnt, m_cnt);
        check("full_o", 32'(full_o), 32'(exp_q.size() == 2));
`endif
    endtask

    initial begin
        int sent;
        int run;
        int b_start;
        logic       pv;
        logic [31:0] pd;

        rst = 1'b1; vld_a = 1'b1; data_a = 32'h55; rdy_b = 1'b1;

        // Reset held two cycles with vld_a high: nothing accepted or presented
        tick();
        tick();
        check("rst_rdy_a", 32'(rdy_a), 32'd0);
        check("rst_vld_b", 32'(vld_b), 32'd0);
        rst = 1'b0; vld_a = 1'b0;
        tick();
        check("rel_rdy_a", 32'(rdy_a), 32'd1);
        check("rel_vld_b", 32'(vld_b), 32'd0);

        // Streaming 1..8 with 1-cycle latency, ready never drops
        for (int i = 1; i <= 8; i++) begin
            data_a = 32'(i); vld_a = 1'b1; rdy_b = 1'b1;
            tick();
            check("stream_data", data_b, 32'(i));
            check("stream_rdy", 32'(rdy_a), 32'd1);
        end
        vld_a = 1'b0;
        tick();
        check("stream_drain", 32'(vld_b), 32'd0);

        // Backpressure: 0x10 main, 0x11 skid, 0x12 refused
        rdy_b = 1'b0; vld_a = 1'b1; data_a = 32'h10;
        tick();
        check("bp_first", data_b, 32'h10);
        data_a = 32'h11;
        tick();
        check("bp_full_rdy", 32'(rdy_a), 32'd0);
        check("bp_hold0", data_b, 32'h10);
        data_a = 32'h12;
        tick();
        check("bp_hold1", data_b, 32'h10);
        check("bp_still_full", 32'(rdy_a), 32'd0);
        rdy_b = 1'b1;
        tick();
        check("bp_out11", data_b, 32'h11);
        check("bp_release", 32'(rdy_a), 32'd1);
        tick();
        check("bp_out12", data_b, 32'h12);
        vld_a = 1'b0;
        tick();
        check("bp_empty", 32'(vld_b), 32'd0);

        // Irregular ready and random source over 200 words
        sent = 0; run = 0; b_start = b_total; rdy_b = 1'b1;
        for (int cyc = 0; cyc < 5000 && (sent < 200 || exp_q.size() != 0); cyc++) begin
            if (run == 0) begin
                rdy_b = !rdy_b;
                run = int'($urandom_range(1, 4));
            end
            run--;
            vld_a  = (sent < 200) && ($urandom_range(0, 1) == 1);
            data_a = 32'h100 + 32'(sent);
            if (vld_a && m_rdy) sent++;
            pv = vld_b && !rdy_b;
            pd = data_b;
            tick();
            if (pv) check("stall_hold", data_b, pd);
        end
        check("irr_sent", 32'(sent), 32'd200);
        check("irr_rcvd", 32'(b_total - b_start), 32'd200);
        check("irr_drained", 32'(exp_q.size()), 32'd0);

        // Reset while FULL discards 0xA and 0xB
        vld_a = 1'b0; rdy_b = 1'b0;
        tick();
        vld_a = 1'b1; data_a = 32'hA;
        tick();
        data_a = 32'hB;
        tick();
        check("mid_full", 32'(rdy_a), 32'd0);
        rst = 1'b1; vld_a = 1'b0;
        tick();
        check("mid_rst_vld", 32'(vld_b), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rel_rdy", 32'(rdy_a), 32'd1);
        vld_a = 1'b1; data_a = 32'hC;
        tick();
        check("mid_next", data_b, 32'hC);
        vld_a = 1'b0; rdy_b = 1'b1;
        tick();
        check("mid_empty", 32'(vld_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
